// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Accepts one operation at a time and alternates grants on a tie.
// Returns each registered result with the id of the requester that issued it.
module alu_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   input  logic             rsp_ready
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [3:0]       op_sel_q, op_sel_d;
   logic             op_id_q, op_id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             last_grant_q, last_grant_d;
   logic             gnt0, gnt1;

   // Next-state, grant decision and operand capture
   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_sel_d     = op_sel_q;
      op_id_d      = op_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      last_grant_d = last_grant_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      unique case (state_q)
         StIdle: begin
            // On a tie the requester that was not served last wins
            gnt0 = req0_valid && (!req1_valid || last_grant_q);
            gnt1 = req1_valid && !gnt0;
            if (gnt0) begin
               op_a_d   = req0_a;
               op_b_d   = req0_b;
               op_sel_d = req0_sel;
               op_id_d  = 1'b0;
               state_d  = StExec;
            end else if (gnt1) begin
               op_a_d   = req1_a;
               op_b_d   = req1_b;
               op_sel_d = req1_sel;
               op_id_d  = 1'b1;
               state_d  = StExec;
            end
         end
         StExec: begin
            rsp_data_d  = alu_out;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d  = 1'b0;
               last_grant_d = rsp_id_q;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_sel_q     <= '0;
         op_id_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_sel_q     <= op_sel_d;
         op_id_q      <= op_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign req0_ready = gnt0 && !rst;
   assign req1_ready = gnt1 && !rst;
   assign alu_a      = op_a_q;
   assign alu_b      = op_b_q;
   assign alu_sel    = op_sel_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic [3:0]       req0_sel;
   logic             req1_valid, req1_ready;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic [3:0]       req1_sel;
   logic [WIDTH-1:0] alu_a, alu_b, alu_out;
   logic [3:0]       alu_sel;
   logic             rsp_valid, rsp_id, rsp_ready;
   logic [WIDTH-1:0] rsp_data;

   int n_cmp = 0;
   int n_err = 0;

   alu_arbiter #(.WIDTH(WIDTH)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sel   (req0_sel),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sel   (req1_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   // Shared ALU in ALUSel encoding
   always_comb begin
      alu_out = '0;
      case (alu_sel)
         4'b0000: alu_out = alu_a + alu_b;
         4'b1000: alu_out = alu_a - alu_b;
         4'b0001: alu_out = alu_a << alu_b[4:0];
         4'b0101: alu_out = alu_a >> alu_b[4:0];
         4'b1101: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         4'b0100: alu_out = alu_a ^ alu_b;
         4'b0110: alu_out = alu_a | alu_b;
         4'b0111: alu_out = alu_a & alu_b;
         default: alu_out = '0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete operation from an idle start with rsp_ready held high.
   // Ends on the falling edge after the handshake, back in idle.
   task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [31:0] exp);
      if (id) begin
         req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1;
      end
      rsp_ready = 1'b1;
      #1;
      check_eq("op grant ready0", {31'd0, req0_ready}, {31'd0, !id});
      check_eq("op grant ready1", {31'd0, req1_ready}, {31'd0, id});
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check_eq("op exec no rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("op exec alu_sel", {28'd0, alu_sel}, {28'd0, sel});
      @(negedge clk);
      check_eq("op rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("op rsp_data", rsp_data, exp);
      check_eq("op rsp_id", {31'd0, rsp_id}, {31'd0, id});
      @(negedge clk);
      check_eq("op back idle", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
      rsp_ready = 1'b0;

      // Reset state, with requests present to confirm readies are masked
      @(negedge clk);
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check_eq("rst ready0", {31'd0, req0_ready}, 32'd0);
      check_eq("rst ready1", {31'd0, req1_ready}, 32'd0);
      check_eq("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst rsp_id", {31'd0, rsp_id}, 32'd0);
      check_eq("rst rsp_data", rsp_data, 32'd0);
      check_eq("rst alu_a", alu_a, 32'd0);
      check_eq("rst alu_b", alu_b, 32'd0);
      check_eq("rst alu_sel", {28'd0, alu_sel}, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;

      // Basic add wrapping to zero, then subtract going negative
      do_op(1'b0, 32'hFFFF_FFFE, 32'd2, 4'b0000, 32'h0000_0000);
      do_op(1'b1, 32'd5, 32'd7, 4'b1000, 32'hFFFF_FFFE);

      // Round-robin from reset with both requesters always valid
      do_reset();
      req0_a = 32'd1;  req0_b = 32'd1; req0_sel = 4'b0000;
      req1_a = 32'd10; req1_b = 32'd3; req1_sel = 4'b1000;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic exp_id;
         exp_id = (i % 2) != 0;
         #1;
         check_eq("rr grant0", {31'd0, req0_ready}, {31'd0, !exp_id});
         check_eq("rr grant1", {31'd0, req1_ready}, {31'd0, exp_id});
         @(negedge clk);
         check_eq("rr exec readies", {30'd0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk);
         check_eq("rr rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check_eq("rr rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
         check_eq("rr rsp_data", rsp_data, exp_id ? 32'd7 : 32'd2);
         @(negedge clk);
      end

      // Back-pressure: last served was 1, so requester 0 is granted next
      rsp_ready = 1'b0;
      #1;
      check_eq("bp grant0", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_eq("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check_eq("bp rsp_data", rsp_data, 32'd2);
         check_eq("bp rsp_id", {31'd0, rsp_id}, 32'd0);
         check_eq("bp readies", {30'd0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check_eq("bp hs rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp hs readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      #1;
      check_eq("bp next grant0", {31'd0, req0_ready}, 32'd0);
      check_eq("bp next grant1", {31'd0, req1_ready}, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check_eq("bp drain id", {31'd0, rsp_id}, 32'd1);
      check_eq("bp drain data", rsp_data, 32'd7);
      @(negedge clk);

      // Reset during EXEC; make last grant 0 first so the tie result is meaningful
      do_op(1'b0, 32'd3, 32'd4, 4'b0000, 32'd7);
      req1_a = 32'd9; req1_b = 32'd2; req1_sel = 4'b1000; req1_valid = 1'b1;
      #1;
      check_eq("mr grant1", {31'd0, req1_ready}, 32'd1);
      @(negedge clk);
      req1_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("mr alu_a", alu_a, 32'd0);
      for (int k = 0; k < 3; k++) begin
         check_eq("mr no rsp", {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
      end
      req0_a = 32'd20; req0_b = 32'd22; req0_sel = 4'b0000;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check_eq("mr tie grant0", {31'd0, req0_ready}, 32'd1);
      check_eq("mr tie grant1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check_eq("mr tie rsp_id", {31'd0, rsp_id}, 32'd0);
      check_eq("mr tie rsp_data", rsp_data, 32'd42);
      @(negedge clk);

      // Arithmetic shift right passes its opcode through
      do_op(1'b0, 32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 The block SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 The block SHALL have port req0_sel  input  4  requester 0 ALU opcode, in ALUSel encoding.
REQ-008 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_b, req1_sel, identical in direction and width to the requester 0 ports, for requester 1.
REQ-009 The block SHALL have ports alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-010 The block SHALL have port alu_sel  output  4  opcode driven to the shared ALU.
REQ-011 The block SHALL have port alu_out  input  WIDTH  combinational ALU result.
REQ-012 The block SHALL have port rsp_valid  output  1  result available.
REQ-013 The block SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-014 The block SHALL have port rsp_data  output  WIDTH  registered ALU result.
REQ-015 The block SHALL have port rsp_ready  input  1  consumer accepts the result.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-017 In IDLE with at least one reqN_valid asserted, the block SHALL grant exactly one requester:
- if only one requester is valid, that requester;
- if both are valid, the requester other than last_grant.
REQ-018 The block SHALL assert reqN_ready combinationally, for exactly one cycle, only in IDLE and only for the granted requester.
REQ-019 On the grant edge the block SHALL capture a, b and sel into operand registers, record the requester id, and move to EXEC.
REQ-020 alu_a, alu_b and alu_sel SHALL be driven from the operand registers at all times.
REQ-021 In EXEC the block SHALL register alu_out into rsp_data and the id into rsp_id, then move to RESP.
REQ-022 In RESP the block SHALL hold rsp_valid=1, with rsp_data and rsp_id stable, until a cycle in which rsp_ready=1.
REQ-023 On the RESP handshake the block SHALL:
- set last_grant to rsp_id;
- deassert rsp_valid;
- return to IDLE.
REQ-024 Timing: a request accepted in cycle N SHALL give rsp_valid=1 in cycle N+2. With rsp_ready held high, throughput SHALL be one operation per 3 cycles.
REQ-025 No reqN_ready SHALL assert outside IDLE, and the block SHALL hold at most one operation in flight.
REQ-026 rsp_ready asserted outside RESP SHALL be ignored.
REQ-027 Opcodes SHALL pass to the ALU unchanged; undefined encodings are the ALU's concern.
REQ-028 Arithmetic SHALL be performed only by the ALU; the block does no width conversion.

Reset
REQ-029 While rst=1 the block SHALL set:
- state=IDLE;
- rsp_valid=0, rsp_id=0, rsp_data=0;
- operand registers=0, so alu_a=alu_b=0 and alu_sel=0;
- last_grant=1, so requester 0 wins the first tie.
REQ-030 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-031 A reset asserted in EXEC or RESP SHALL abandon the operation; no response for it SHALL ever appear.

Verification
REQ-032 Basic add: req0 add, a=0xFFFFFFFE, b=2, sel=0000, rsp_ready=1 -> req0_ready=1 at cycle N; rsp_valid=1 at N+2 with rsp_data=0x00000000, rsp_id=0.
REQ-033 Subtract: req1 sub, a=5, b=7, sel=1000 -> rsp_data=0xFFFFFFFE, rsp_id=1.
REQ-034 Round-robin: after reset, both requesters valid continuously -> grants alternate 0,1,0,1; each response id matches its grant order.
REQ-035 Back-pressure: rsp_ready=0 for 3 cycles in RESP with both requesters valid -> rsp_valid, rsp_data and rsp_id stable; both readies stay 0; one grant follows the cycle after the handshake.
REQ-036 Reset mid-operation: rst=1 for one cycle in EXEC -> no rsp_valid; alu_a=0 after reset; the next tie grants requester 0.
REQ-037 Shift passthrough: req0 sra, a=0x80000000, b=4, sel=1101 -> alu_sel=1101 during EXEC; rsp_data=0xF8000000.
